// File: rtl/dram_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dram_port_ctrl
// Single-port DRAM word array behind the CNN top level: prioritised reads, a
//   forwarding write buffer and a host preload/dump port.
//   Optional macro: DRAM_ACCESS_CNT_EN (read/write/forward access counters).
// Revision : 1.0
// ============================================================================
module dram_port_ctrl #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 64,
    parameter int WBUF_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          DRAMreadEn,
    input  logic [ADDR_W-1:0]             DRAMreadAddr,
    output logic [DATA_W-1:0]             ifmap,
    input  logic                          DRAMwriteEn,
    input  logic [ADDR_W-1:0]             DRAMwriteAddr,
    input  logic [DATA_W-1:0]             DRAMwriteData,
    input  logic                          host_en,
    input  logic                          host_we,
    input  logic [ADDR_W-1:0]             host_addr,
    input  logic [DATA_W-1:0]             host_wdata,
    output logic                          host_ready,
    output logic                          host_rvalid,
    output logic [DATA_W-1:0]             host_rdata,
    output logic [$clog2(WBUF_DEPTH):0]   wbuf_cnt,
    output logic                          wbuf_ovf,
    output logic                          idle
`ifdef DRAM_ACCESS_CNT_EN
    ,
    output logic [15:0]                   rd_count,
    output logic [15:0]                   wr_count,
    output logic [15:0]                   fwd_count
`endif
);

    localparam int PTR_W = $clog2(WBUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q     [DEPTH];
    logic [ADDR_W-1:0] wb_addr_q [WBUF_DEPTH];
    logic [DATA_W-1:0] wb_data_q [WBUF_DEPTH];

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] ifmap_q, ifmap_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic              host_rvalid_q, host_rvalid_d;

    logic              w_drain;
    logic              w_full;
    logic              w_push;
    logic              w_fwd_hit;
    logic [DATA_W-1:0] w_fwd_data;

    // Reads own the port; drains take any cycle the top level is not reading.
    assign w_drain    = ~DRAMreadEn & (cnt_q != '0);
    assign w_full     = (cnt_q == CNT_W'(WBUF_DEPTH));
    assign w_push     = DRAMwriteEn & (~w_full | w_drain);
    assign host_ready = host_en & ~DRAMreadEn & (cnt_q == '0);

    logic [PTR_W-1:0]      w_age_idx [WBUF_DEPTH];
    logic [WBUF_DEPTH-1:0] w_age_hit;

    genvar g;
    generate
        for (g = 0; g < WBUF_DEPTH; g++) begin : g_fwd
            assign w_age_idx[g] = rd_ptr_q + PTR_W'(g);
            assign w_age_hit[g] = (CNT_W'(g) < cnt_q) &&
                                  (wb_addr_q[w_age_idx[g]] == DRAMreadAddr);
        end
    endgenerate

    // Scan oldest to youngest so the last match (youngest) wins.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        for (int k = 0; k < WBUF_DEPTH; k++) begin
            if (w_age_hit[k]) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = wb_data_q[w_age_idx[k]];
            end
        end
    end

    always_comb begin
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        cnt_d         = cnt_q;
        ovf_d         = ovf_q;
        ifmap_d       = ifmap_q;
        host_rdata_d  = host_rdata_q;
        host_rvalid_d = 1'b0;

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (w_drain) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (w_push && !w_drain) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!w_push && w_drain) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (DRAMwriteEn && !w_push) begin
            ovf_d = 1'b1;
        end

        if (DRAMreadEn) begin
            ifmap_d = w_fwd_hit ? w_fwd_data : mem_q[DRAMreadAddr];
        end
        if (host_ready && !host_we) begin
            host_rdata_d  = mem_q[host_addr];
            host_rvalid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            cnt_q         <= '0;
            ovf_q         <= 1'b0;
            ifmap_q       <= '0;
            host_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            cnt_q         <= cnt_d;
            ovf_q         <= ovf_d;
            ifmap_q       <= ifmap_d;
            host_rdata_q  <= host_rdata_d;
            host_rvalid_q <= host_rvalid_d;
        end
    end

    // Storage has no reset; emptiness is tracked purely by the pointers/count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            wb_addr_q[wr_ptr_q] <= DRAMwriteAddr;
            wb_data_q[wr_ptr_q] <= DRAMwriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (w_drain) begin
            mem_q[wb_addr_q[rd_ptr_q]] <= wb_data_q[rd_ptr_q];
        end else if (host_ready && host_we) begin
            mem_q[host_addr] <= host_wdata;
        end
    end

    assign ifmap       = ifmap_q;
    assign host_rdata  = host_rdata_q;
    assign host_rvalid = host_rvalid_q;
    assign wbuf_cnt    = cnt_q;
    assign wbuf_ovf    = ovf_q;
    assign idle        = (cnt_q == '0) & ~DRAMreadEn & ~DRAMwriteEn & ~host_en;

`ifdef DRAM_ACCESS_CNT_EN
    logic [15:0] rd_cnt_q;
    logic [15:0] wr_cnt_q;
    logic [15:0] fwd_cnt_q;
    logic        w_cnt_clr;

    // Magic host write to address 0 clears the counters; the write still lands.
    assign w_cnt_clr = host_ready & host_we & (host_addr == '0) &
                       (host_wdata == DATA_W'(64'hC1EA_0000_0000_0000));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            fwd_cnt_q <= '0;
        end else if (w_cnt_clr) begin
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            fwd_cnt_q <= '0;
        end else begin
            if (DRAMreadEn && rd_cnt_q != 16'hFFFF) begin
                rd_cnt_q <= rd_cnt_q + 16'd1;
            end
            if (w_push && wr_cnt_q != 16'hFFFF) begin
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end
            if (DRAMreadEn && w_fwd_hit && fwd_cnt_q != 16'hFFFF) begin
                fwd_cnt_q <= fwd_cnt_q + 16'd1;
            end
        end
    end

    assign rd_count  = rd_cnt_q;
    assign wr_count  = wr_cnt_q;
    assign fwd_count = fwd_cnt_q;
`endif

endmodule
`default_nettype wire
